// File: rtl/scan_ctrl.sv
// Scan-chain load/capture/unload controller: streams pattern bytes into the chain and
// returns the captured response as bytes. Define SCAN_CTRL_SIG_EN to build the response signature.
module scan_ctrl #(
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNTBITS   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             test_si,
    output logic             test_se,
    input  logic             test_so,
    output logic             chain_clk_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sig
);

    localparam logic [CNTBITS-1:0] LenC       = CNTBITS'(CHAIN_LEN);
    localparam logic [CNTBITS-1:0] LastC      = CNTBITS'(CHAIN_LEN - 1);
    localparam logic [CNTBITS-1:0] WidthC     = CNTBITS'(WIDTH);
    localparam logic [CNTBITS-1:0] WidthLastC = CNTBITS'(WIDTH - 1);
    localparam logic [CNTBITS-1:0] OneC       = CNTBITS'(1);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StCapture,
        StUnload,
        StDone
    } state_e;

    state_e             state;
    logic [WIDTH-1:0]   pat_buf;
    logic [CNTBITS-1:0] buf_cnt;   // pattern bits still held in pat_buf
    logic [CNTBITS-1:0] fetched;   // pattern bits accepted so far this sequence
    logic [CNTBITS-1:0] cnt;       // chain bits shifted (SHIFT) or unloaded (UNLOAD)
    logic [CNTBITS-1:0] pos;
    logic [WIDTH-1:0]   acc;

    logic               shift_en;
    logic               unload_en;
    logic               din_fire;
    logic               dout_fire;
    logic               byte_end;
    logic [CNTBITS-1:0] remain;
    logic [CNTBITS-1:0] take;
    logic [WIDTH-1:0]   so_word;

    assign shift_en  = (state == StShift) && (buf_cnt != '0);
    assign din_ready = (state == StShift) && (fetched != LenC) && (buf_cnt <= OneC);
    assign din_fire  = din_valid && din_ready;
    assign remain    = LenC - fetched;
    // A short final byte contributes only the bits the chain still needs.
    assign take      = (remain > WidthC) ? WidthC : remain;

    // The chain may advance in the same cycle the pending response byte is taken.
    assign unload_en = (state == StUnload) && (cnt != LenC) && (!dout_valid || dout_ready);
    assign dout_fire = dout_valid && dout_ready;
    assign byte_end  = (pos == WidthLastC) || (cnt == LastC);
    assign so_word   = {{(WIDTH - 1){1'b0}}, test_so} << pos;

    assign test_se      = (state == StShift) || (state == StUnload);
    assign test_si      = shift_en && pat_buf[0];
    assign chain_clk_en = shift_en || (state == StCapture) || unload_en;
    assign busy         = (state != StIdle);
    assign done         = (state == StDone);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= StIdle;
            pat_buf    <= '0;
            buf_cnt    <= '0;
            fetched    <= '0;
            cnt        <= '0;
            pos        <= '0;
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        state      <= StShift;
                        buf_cnt    <= '0;
                        fetched    <= '0;
                        cnt        <= '0;
                        pos        <= '0;
                        acc        <= '0;
                        dout_valid <= 1'b0;
                    end
                end
                StShift: begin
                    if (shift_en) begin
                        pat_buf <= pat_buf >> 1;
                        buf_cnt <= buf_cnt - OneC;
                        if (cnt == LastC) begin
                            state <= StCapture;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + OneC;
                        end
                    end
                    // A refill lands on the same edge the last buffered bit leaves.
                    if (din_fire) begin
                        pat_buf <= din;
                        buf_cnt <= take;
                        fetched <= fetched + take;
                    end
                end
                StCapture: begin
                    state <= StUnload;
                    pos   <= '0;
                    acc   <= '0;
                end
                StUnload: begin
                    if (dout_fire) begin
                        dout_valid <= 1'b0;
                    end
                    if (unload_en) begin
                        cnt <= cnt + OneC;
                        if (byte_end) begin
                            dout       <= acc | so_word;
                            dout_valid <= 1'b1;
                            acc        <= '0;
                            pos        <= '0;
                        end else begin
                            acc <= acc | so_word;
                            pos <= pos + OneC;
                        end
                    end
                    if (dout_fire && (cnt == LenC)) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef SCAN_CTRL_SIG_EN
    logic [WIDTH-1:0] sig_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sig_q <= '0;
        end else if ((state == StIdle) && start) begin
            sig_q <= '0;
        end else if (unload_en) begin
            sig_q <= {sig_q[WIDTH-2:0], sig_q[WIDTH-1] ^ test_so};
        end
    end

    assign sig = sig_q;
`else
    assign sig = '0;
`endif

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: two instances (16-bit and 12-bit chains) driving behavioural chain models
// that invert their contents on capture; responses are checked against a scoreboard.
module tb_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       a_reset, a_start, a_din_valid, a_din_ready, a_dout_valid, a_dout_ready;
    logic       a_test_si, a_test_se, a_test_so, a_chain_clk_en, a_busy, a_done;
    logic [7:0] a_din, a_dout, a_sig;
    logic [15:0] a_chain = '0;

    logic       b_reset, b_start, b_din_valid, b_din_ready, b_dout_valid, b_dout_ready;
    logic       b_test_si, b_test_se, b_test_so, b_chain_clk_en, b_busy, b_done;
    logic [7:0] b_din, b_dout, b_sig;
    logic [11:0] b_chain = '0;

    assign a_test_so = a_chain[0];
    assign b_test_so = b_chain[0];

    scan_ctrl #(.CHAIN_LEN(16), .WIDTH(8), .CNTBITS(8)) dut16 (
        .clk(clk), .reset(a_reset), .start(a_start),
        .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
        .dout(a_dout), .dout_valid(a_dout_valid), .dout_ready(a_dout_ready),
        .test_si(a_test_si), .test_se(a_test_se), .test_so(a_test_so),
        .chain_clk_en(a_chain_clk_en), .busy(a_busy), .done(a_done), .sig(a_sig)
    );

    scan_ctrl #(.CHAIN_LEN(12), .WIDTH(8), .CNTBITS(8)) dut12 (
        .clk(clk), .reset(b_reset), .start(b_start),
        .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
        .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
        .test_si(b_test_si), .test_se(b_test_se), .test_so(b_test_so),
        .chain_clk_en(b_chain_clk_en), .busy(b_busy), .done(b_done), .sig(b_sig)
    );

    // Chain models: shift toward bit 0 when scan-enabled, invert contents on capture.
    always @(posedge clk) begin
        if (a_chain_clk_en) begin
            if (a_test_se) a_chain <= {a_test_si, a_chain[15:1]};
            else           a_chain <= ~a_chain;
        end
        if (b_chain_clk_en) begin
            if (b_test_se) b_chain <= {b_test_si, b_chain[11:1]};
            else           b_chain <= ~b_chain;
        end
    end

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int   r_lat, r_ce, r_pulses, r_stall_bad;
    logic r_sig_nz;

    // One sequence on the 16-bit instance; results land in r_* and the two queues.
    task automatic run16(input logic [7:0] p0, input logic [7:0] p1, input int din_gap,
                         input int rdy_gap, input int start_at, input int abort_at);
        logic [7:0] pat [2];
        int sent, gap, rwait, ngot, cyc, sh, unl;
        logic capt_seen;
        pat[0] = p0; pat[1] = p1;
        sent = 0; gap = 0; rwait = 0; ngot = 0; cyc = 0; sh = 0; unl = 0; capt_seen = 1'b0;
        r_lat = -1; r_ce = 0; r_pulses = 0; r_stall_bad = 0; r_sig_nz = 1'b0;
        @(negedge clk);
        a_start = 1'b1; a_din = p0; a_din_valid = 1'b1; a_dout_ready = 1'b1;
        @(posedge clk);
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            a_start = (cyc == start_at);
            if (abort_at >= 0 && unl >= abort_at) begin
                a_reset = 1'b0;
                a_din_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            if (sent < 2) begin
                a_din = pat[sent];
                a_din_valid = (sent == 0) || (gap >= din_gap);
                if (!a_din_valid && a_din_ready) gap++;
                if (a_din_valid && a_din_ready) begin
                    exp_q.push_back(~pat[sent]);
                    sent++;
                end
            end else begin
                a_din_valid = 1'b0;
            end
            a_dout_ready = 1'b1;
            if (a_dout_valid && ngot == 0 && rwait < rdy_gap) begin
                a_dout_ready = 1'b0;
                rwait++;
            end
            if (a_dout_valid && a_dout_ready) begin
                got_q.push_back(a_dout);
                ngot++;
            end
            #1;
            if (a_chain_clk_en) r_ce++;
            if (a_dout_valid && !a_dout_ready && a_chain_clk_en) r_stall_bad++;
            if (a_test_se && !capt_seen && sh == 8 && a_din_ready && !a_din_valid && a_chain_clk_en)
                r_stall_bad++;
            if (a_test_se && !capt_seen && a_chain_clk_en) sh++;
            if (a_busy && !a_test_se) capt_seen = 1'b1;
            if (capt_seen && a_test_se) unl++;
            if (a_sig !== 8'h00) r_sig_nz = 1'b1;
            if (a_done) begin
                r_pulses++;
                if (r_lat < 0) r_lat = cyc - 1;
            end
            if (r_lat >= 0 && cyc >= r_lat + 5) break;
        end
        a_start = 1'b0;
        a_din_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] va, vb;
        a_reset = 1'b0; b_reset = 1'b0;
        a_start = 1'b0; a_din = '0; a_din_valid = 1'b0; a_dout_ready = 1'b0;
        b_start = 1'b0; b_din = '0; b_din_valid = 1'b0; b_dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        va = {a_test_se, a_test_si, a_chain_clk_en, a_din_ready, a_dout, a_dout_valid, a_busy,
              a_done, a_sig};
        vb = {b_test_se, b_test_si, b_chain_clk_en, b_din_ready, b_dout, b_dout_valid, b_busy,
              b_done, b_sig};
        checks++;
        if (va !== 23'd0) begin errors++; $display("FAIL reset16_outputs: got %h want 0", va); end
        checks++;
        if (vb !== 23'd0) begin errors++; $display("FAIL reset12_outputs: got %h want 0", vb); end
        a_reset = 1'b1; b_reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] e, g, sig_ref;
        exp_q.delete(); got_q.delete();
        run16(8'hA5, 8'h3C, 0, 0, -1, -1);
        checks++;
        if (r_lat !== 35) begin errors++; $display("FAIL basic_latency: got %0d want 35", r_lat); end
        checks++;
        if (r_pulses !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", r_pulses); end
        checks++;
        if (r_ce !== 33) begin errors++; $display("FAIL basic_chain_clocks: got %0d want 33", r_ce); end
        sig_ref = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            for (int j = 0; j < 8; j++) sig_ref = {sig_ref[6:0], sig_ref[7] ^ e[j]};
        end
`ifdef SCAN_CTRL_SIG_EN
        checks++;
        if (a_sig !== sig_ref) begin errors++; $display("FAIL basic_sig: got %h want %h", a_sig, sig_ref); end
`else
        checks++;
        if (r_sig_nz !== 1'b0) begin errors++; $display("FAIL basic_sig_zero: got nonzero want 0"); end
`endif
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() != 2) begin
            errors++;
            $display("FAIL basic_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL basic_dout: got %h want %h", g, e); end
        end
    endtask

    task automatic test_stalls();
        logic [7:0] e, g;
        exp_q.delete(); got_q.delete();
        run16(8'hA5, 8'h3C, 5, 7, -1, -1);
        checks++;
        if (r_lat !== 47) begin errors++; $display("FAIL stall_latency: got %0d want 47", r_lat); end
        checks++;
        if (r_ce !== 33) begin errors++; $display("FAIL stall_chain_clocks: got %0d want 33", r_ce); end
        checks++;
        if (r_stall_bad !== 0) begin errors++; $display("FAIL stall_clk_en: got %0d clocked stall cycles want 0", r_stall_bad); end
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() != 2) begin
            errors++;
            $display("FAIL stall_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL stall_dout: got %h want %h", g, e); end
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] e, g;
        exp_q.delete(); got_q.delete();
        run16(8'hA5, 8'h3C, 0, 0, 5, -1);
        checks++;
        if (r_pulses !== 1) begin errors++; $display("FAIL restart_done_pulses: got %0d want 1", r_pulses); end
        checks++;
        if (r_lat !== 35) begin errors++; $display("FAIL restart_latency: got %0d want 35", r_lat); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL restart_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL restart_dout: got %h want %h", g, e); end
        end
    endtask

    task automatic test_abort();
        logic [22:0] v;
        logic [7:0] e, g;
        exp_q.delete(); got_q.delete();
        run16(8'hA5, 8'h3C, 0, 0, -1, 4);
        v = {a_test_se, a_test_si, a_chain_clk_en, a_din_ready, a_dout, a_dout_valid, a_busy,
             a_done, a_sig};
        checks++;
        if (v !== 23'd0) begin errors++; $display("FAIL abort_outputs: got %h want 0", v); end
        checks++;
        if (r_pulses !== 0) begin errors++; $display("FAIL abort_done_pulses: got %0d want 0", r_pulses); end
        a_reset = 1'b1;
        exp_q.delete(); got_q.delete();
        run16(8'hA5, 8'h3C, 0, 0, -1, -1);
        checks++;
        if (r_lat !== 35) begin errors++; $display("FAIL abort_rerun_latency: got %0d want 35", r_lat); end
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() != 2) begin
            errors++;
            $display("FAIL abort_rerun_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL abort_rerun_dout: got %h want %h", g, e); end
        end
    endtask

    task automatic test_chain12();
        logic [7:0] pat [3];
        logic [7:0] e, g, mask;
        int sent, xfers, lat12, rem;
        pat[0] = 8'hFF; pat[1] = 8'h0F; pat[2] = 8'h55;
        exp_q.delete(); got_q.delete();
        sent = 0; xfers = 0; lat12 = -1;
        @(negedge clk);
        b_start = 1'b1; b_din = pat[0]; b_din_valid = 1'b1; b_dout_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc < 200 && (lat12 < 0 || cyc < lat12 + 6); cyc++) begin
            @(negedge clk);
            b_start = 1'b0;
            b_din = pat[(sent > 2) ? 2 : sent];
            if (b_din_ready) begin
                xfers++;
                if (sent < 2) begin
                    rem = 12 - 8 * sent;
                    mask = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
                    exp_q.push_back(~b_din & mask);
                end
                sent++;
            end
            if (b_dout_valid) got_q.push_back(b_dout);
            #1;
            if (b_done && lat12 < 0) lat12 = cyc - 1;
        end
        b_din_valid = 1'b0;
        checks++;
        if (xfers !== 2) begin errors++; $display("FAIL c12_din_xfers: got %0d want 2", xfers); end
        checks++;
        if (lat12 !== 27) begin errors++; $display("FAIL c12_latency: got %0d want 27", lat12); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL c12_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL c12_dout: got %h want %h", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_start_ignored();
        test_abort();
        test_chain12();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter: CHAIN_LEN, 16, scan chain length in bits (>=2).
REQ-002 Parameter: WIDTH, 8, host data byte width.
REQ-003 Parameter: CNTBITS, 8, bit counter width; SHALL satisfy 2^CNTBITS > CHAIN_LEN.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset.
REQ-006 Port: start  in  1  begins one load/capture/unload sequence; sampled only in IDLE.
REQ-007 Port: din, din_valid, din_ready  in/in/out  WIDTH/1/1  pattern byte stream; transfer when valid&ready.
REQ-008 Port: dout, dout_valid, dout_ready  out/out/in  WIDTH/1/1  response byte stream; transfer when valid&ready.
REQ-009 Port: test_si  out  1  serial scan data to the chain.
REQ-010 Port: test_se  out  1  scan enable to the chain.
REQ-011 Port: test_so  in  1  serial scan data from the chain.
REQ-012 Port: chain_clk_en  out  1  chain clock-gate enable; chain advances only on cycles where this is 1.
REQ-013 Port: busy, done  out  1/1  busy=1 outside IDLE; done is a 1-cycle pulse.
REQ-014 Port: sig  out  WIDTH  response signature (see Configuration).

Function
REQ-015 FSM states: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
REQ-016 Transitions: IDLE->SHIFT on start; SHIFT->CAPTURE after CHAIN_LEN bits shifted; CAPTURE->UNLOAD after exactly 1 cycle; UNLOAD->DONE after CHAIN_LEN bits unloaded; DONE->IDLE after 1 cycle.
REQ-017 start while not IDLE SHALL be ignored.
REQ-018 SHIFT: single-byte input buffer; din_ready=1 when the buffer is empty or its last bit is being shifted this cycle; din_ready=0 outside SHIFT.
REQ-019 SHIFT: din bits sent LSB first; first test_si bit = din[0] of first byte.
REQ-020 SHIFT: on each cycle with a buffered bit, test_se=1, chain_clk_en=1, test_si=that bit; with no bit available (stall), test_se=1, chain_clk_en=0.
REQ-021 If CHAIN_LEN is not a multiple of WIDTH, the upper unused bits of the final pattern byte SHALL be discarded; no extra byte is requested.
REQ-022 CAPTURE: test_se=0, chain_clk_en=1, test_si=0 for exactly one cycle.
REQ-023 UNLOAD: test_se=1, test_si=0; test_so bit k (0-based) written into response bit (k mod WIDTH), so the first bit out lands in dout[0].
REQ-024 UNLOAD: dout_valid asserts once WIDTH bits are assembled, or after the last chain bit (upper bits zero-padded); dout holds stable while dout_valid=1 and dout_ready=0.
REQ-025 UNLOAD: chain_clk_en=0 on any cycle where the assembled byte is complete and not yet accepted (backpressure stall); test_so is not sampled on such cycles.
REQ-026 DONE is entered only after the final response byte is accepted; done=1 for that single cycle.
REQ-027 Bits shifted in SHIFT + bits unloaded SHALL each equal exactly CHAIN_LEN regardless of stalls.
REQ-028 Minimum latency start->done with no stalls and din available: 2*CHAIN_LEN + 3 cycles.

Reset
REQ-029 reset=0 at a rising edge: state=IDLE, counters and buffers cleared, all outputs 0 (test_se, test_si, chain_clk_en, din_ready, dout, dout_valid, busy, done, sig), on the next edge.
REQ-030 Reset mid-sequence SHALL abort immediately; partially buffered bytes are dropped; no done pulse.

Configuration
REQ-031 Macro SCAN_CTRL_SIG_EN defined: sig cleared on accepted start; each sampled UNLOAD bit b updates sig <= {sig[WIDTH-2:0], sig[WIDTH-1]^b}; value held after DONE until next start.
REQ-032 SCAN_CTRL_SIG_EN undefined: signature logic not built; sig constant 0.

Verification (bench models the chain as a CHAIN_LEN shift register clocked when chain_clk_en=1; on capture it loads the bitwise inverse of its contents)
REQ-033 CHAIN_LEN=16; din 8'hA5, 8'h3C, dout_ready=1 -> dout 8'h5A then 8'hC3, done 35 cycles after start.
REQ-034 CHAIN_LEN=12; din 8'hFF, 8'h0F -> dout 8'h00 then 8'h00 (upper 4 bits padded zero), exactly 2 din transfers.
REQ-035 din_valid withheld 5 cycles between bytes, dout_ready low 7 cycles on first byte -> same data as REQ-033, chain_clk_en=0 throughout both stalls, done 47 cycles after start.
REQ-036 reset=0 during UNLOAD -> next cycle all outputs 0, state IDLE; new start with REQ-033 stimulus -> REQ-033 response.
REQ-037 start pulsed during SHIFT -> ignored, exactly one done pulse.
REQ-038 SCAN_CTRL_SIG_EN, REQ-033 stimulus -> sig equals bench reference rotate-XOR over the 16 unloaded bits; without macro sig=0 throughout.
